// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multicycle main control FSM:
// state codes, opcode constants, ALU-op and mux-select encodings,
// and the packed control word produced by the output decoder.
package mc_ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11,
      S_MULEX   = 4'd12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_SB    = 6'b101000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_MUL   = 6'b011100;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_MUL   = 2'b11;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       pcwrite;
      logic       branch;
      logic       iord;
      logic       memwrite;
      logic       irwrite;
      logic       regwrite;
      logic       regdst;
      logic       memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [1:0] aluop;
   } ctrl_t;

endpackage

// File: rtl/mc_ctrl_outdec.sv
// Combinational state -> control-word decode for mc_main_ctrl.
// Ports:
//   state     current FSM state
//   mem_ready memory port ready (FETCH loads IR/PC only when ready)
//   ctrl      decoded control word; fields not set for a state are 0
module mc_ctrl_outdec
   import mc_ctrl_pkg::*;
(
   input  state_t state,
   input  logic   mem_ready,
   output ctrl_t  ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl.alusrcb = SRCB_FOUR;
            ctrl.aluop   = ALUOP_ADD;
            ctrl.irwrite = mem_ready;
            ctrl.pcwrite = mem_ready;
         end
         S_DECODE: begin
            ctrl.alusrcb = SRCB_IMM_SH2;
            ctrl.aluop   = ALUOP_ADD;
         end
         S_MEMADR, S_ADDIEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_IMM;
            ctrl.aluop   = ALUOP_ADD;
         end
         S_MEMRD: ctrl.iord = 1'b1;
         S_MEMWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.memtoreg = 1'b1;
         end
         S_MEMWR: begin
            ctrl.iord     = 1'b1;
            ctrl.memwrite = 1'b1;
         end
         S_RTYPEEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_REG;
            ctrl.aluop   = ALUOP_FUNCT;
         end
         S_RTYPEWB: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = 1'b1;
         end
         S_BEQEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_REG;
            ctrl.aluop   = ALUOP_SUB;
            ctrl.branch  = 1'b1;
            ctrl.pcsrc   = PCSRC_ALUOUT;
         end
         S_ADDIWB: ctrl.regwrite = 1'b1;
         S_JEX: begin
            ctrl.pcwrite = 1'b1;
            ctrl.pcsrc   = PCSRC_JUMP;
         end
         S_MULEX: begin
            ctrl.alusrca = 1'b1;
            ctrl.alusrcb = SRCB_REG;
            ctrl.aluop   = ALUOP_MUL;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle main control FSM: sequences fetch, decode, execute and
// writeback for the MIPS-subset core.
// Ports:
//   clk_i, rst_n_i         clock, async active-low reset
//   opcode_i               instr[31:26] from the instruction register
//   mem_ready_i            memory access completes this cycle
//   zero_i                 ALU zero (gated with branch_o in the datapath)
//   pcwrite_o..aluop_o     datapath control word
//   illegal_o              one-cycle pulse after decoding an unknown opcode
//   state_o                current state code, for debug
module mc_main_ctrl
   import mc_ctrl_pkg::*;
#(
   parameter int unsigned MUL_LAT = 4,
   parameter int unsigned CNT_W   = 4
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [5:0] opcode_i,
   input  logic       mem_ready_i,
   input  logic       zero_i,
   output logic       pcwrite_o,
   output logic       branch_o,
   output logic       iord_o,
   output logic       memwrite_o,
   output logic       irwrite_o,
   output logic       regwrite_o,
   output logic       regdst_o,
   output logic       memtoreg_o,
   output logic       alusrca_o,
   output logic [1:0] alusrcb_o,
   output logic [1:0] pcsrc_o,
   output logic [1:0] aluop_o,
   output logic       illegal_o,
   output logic [3:0] state_o
);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] mul_cnt;
   logic             mul_last;
   logic             illegal_q;
   logic             illegal_nxt;
   ctrl_t            dec;
   ctrl_t            ctrl;
   logic             unused_zero;

   // zero_i only matters to the datapath's branch gating
   assign unused_zero = zero_i;

   assign mul_last = (mul_cnt == CNT_W'(MUL_LAT - 1));

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state     <= S_FETCH;
         mul_cnt   <= '0;
         illegal_q <= 1'b0;
      end else begin
         state     <= state_nxt;
         illegal_q <= illegal_nxt;
         // MULEX is only entered from DECODE, so clearing there is the entry load
         if (state == S_DECODE) begin
            mul_cnt <= '0;
         end else if (state == S_MULEX) begin
            mul_cnt <= mul_cnt + CNT_W'(1);
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      illegal_nxt = 1'b0;
      case (state)
         S_FETCH: if (mem_ready_i) state_nxt = S_DECODE;
         S_DECODE: begin
            case (opcode_i)
               OP_RTYPE:     state_nxt = S_RTYPEEX;
               OP_LB, OP_SB: state_nxt = S_MEMADR;
               OP_ADDI:      state_nxt = S_ADDIEX;
               OP_BEQ:       state_nxt = S_BEQEX;
               OP_J:         state_nxt = S_JEX;
               OP_MUL:       state_nxt = S_MULEX;
               default: begin
                  state_nxt   = S_FETCH;
                  illegal_nxt = 1'b1;
               end
            endcase
         end
         S_MEMADR:  state_nxt = (opcode_i == OP_SB) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   if (mem_ready_i) state_nxt = S_MEMWB;
         S_MEMWB:   state_nxt = S_FETCH;
         S_MEMWR:   if (mem_ready_i) state_nxt = S_FETCH;
         S_RTYPEEX: state_nxt = S_RTYPEWB;
         S_RTYPEWB: state_nxt = S_FETCH;
         S_BEQEX:   state_nxt = S_FETCH;
         S_ADDIEX:  state_nxt = S_ADDIWB;
         S_ADDIWB:  state_nxt = S_FETCH;
         S_JEX:     state_nxt = S_FETCH;
         S_MULEX:   if (mul_last) state_nxt = S_RTYPEWB;
         default:   state_nxt = S_FETCH;
      endcase
   end

   mc_ctrl_outdec u_outdec (
      .state     (state),
      .mem_ready (mem_ready_i),
      .ctrl      (dec)
   );

   // Gate the decode with reset so the Mealy FETCH terms cannot leak out
   always_comb begin
      ctrl = '0;
      if (rst_n_i) ctrl = dec;
   end

   assign pcwrite_o  = ctrl.pcwrite;
   assign branch_o   = ctrl.branch;
   assign iord_o     = ctrl.iord;
   assign memwrite_o = ctrl.memwrite;
   assign irwrite_o  = ctrl.irwrite;
   assign regwrite_o = ctrl.regwrite;
   assign regdst_o   = ctrl.regdst;
   assign memtoreg_o = ctrl.memtoreg;
   assign alusrca_o  = ctrl.alusrca;
   assign alusrcb_o  = ctrl.alusrcb;
   assign pcsrc_o    = ctrl.pcsrc;
   assign aluop_o    = ctrl.aluop;
   assign illegal_o  = illegal_q;
   assign state_o    = state;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Directed self-checking bench for mc_main_ctrl (MUL_LAT=4).
module tb_mc_main_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       zero;
   logic       pcwrite, branch, iord, memwrite, irwrite, regwrite;
   logic       regdst, memtoreg, alusrca, illegal;
   logic [1:0] alusrcb, pcsrc, aluop;
   logic [3:0] state;
   logic [14:0] ow;

   int total = 0;
   int bad   = 0;

   // Control word: pcwrite,branch,iord,memwrite,irwrite,regwrite,regdst,
   //               memtoreg,alusrca,alusrcb[2],pcsrc[2],aluop[2]
   localparam logic [14:0] W_FR   = 15'b1_0_0_0_1_0_0_0_0_01_00_00;
   localparam logic [14:0] W_FN   = 15'b0_0_0_0_0_0_0_0_0_01_00_00;
   localparam logic [14:0] W_DEC  = 15'b0_0_0_0_0_0_0_0_0_11_00_00;
   localparam logic [14:0] W_MADR = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
   localparam logic [14:0] W_MRD  = 15'b0_0_1_0_0_0_0_0_0_00_00_00;
   localparam logic [14:0] W_MWB  = 15'b0_0_0_0_0_1_0_1_0_00_00_00;
   localparam logic [14:0] W_MWR  = 15'b0_0_1_1_0_0_0_0_0_00_00_00;
   localparam logic [14:0] W_REX  = 15'b0_0_0_0_0_0_0_0_1_00_00_10;
   localparam logic [14:0] W_RWB  = 15'b0_0_0_0_0_1_1_0_0_00_00_00;
   localparam logic [14:0] W_BEQ  = 15'b0_1_0_0_0_0_0_0_1_00_01_01;
   localparam logic [14:0] W_AEX  = 15'b0_0_0_0_0_0_0_0_1_10_00_00;
   localparam logic [14:0] W_AWB  = 15'b0_0_0_0_0_1_0_0_0_00_00_00;
   localparam logic [14:0] W_JEX  = 15'b1_0_0_0_0_0_0_0_0_00_10_00;
   localparam logic [14:0] W_MUL  = 15'b0_0_0_0_0_0_0_0_1_00_00_11;

   mc_main_ctrl #(.MUL_LAT(4), .CNT_W(4)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .opcode_i    (opcode),
      .mem_ready_i (mem_ready),
      .zero_i      (zero),
      .pcwrite_o   (pcwrite),
      .branch_o    (branch),
      .iord_o      (iord),
      .memwrite_o  (memwrite),
      .irwrite_o   (irwrite),
      .regwrite_o  (regwrite),
      .regdst_o    (regdst),
      .memtoreg_o  (memtoreg),
      .alusrca_o   (alusrca),
      .alusrcb_o   (alusrcb),
      .pcsrc_o     (pcsrc),
      .aluop_o     (aluop),
      .illegal_o   (illegal),
      .state_o     (state)
   );

   always #5 clk = ~clk;

   assign ow = {pcwrite, branch, iord, memwrite, irwrite, regwrite, regdst,
                memtoreg, alusrca, alusrcb, pcsrc, aluop};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // One clock cycle: drive mem_ready, check state/outputs, advance past the edge
   task automatic cyc(input string tag, input logic rdy, input logic [3:0] st,
                      input logic [14:0] w, input logic il);
      mem_ready = rdy;
      #1;
      check({tag, ".state"}, {28'd0, state}, {28'd0, st});
      check({tag, ".ctl"},   {17'd0, ow},    {17'd0, w});
      check({tag, ".ill"},   {31'd0, illegal}, {31'd0, il});
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      mem_ready = 1'b1;
      opcode    = 6'b000000;
      zero      = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst.state", {28'd0, state}, 32'd0);
      check("rst.ctl",   {17'd0, ow},    32'd0);
      check("rst.ill",   {31'd0, illegal}, 32'd0);

      // release with memory not ready: FETCH must not load IR/PC
      mem_ready = 1'b0;
      rst_n     = 1'b1;
      cyc("fw0", 1'b0, 4'd0, W_FN, 1'b0);
      cyc("fw1", 1'b0, 4'd0, W_FN, 1'b0);

      // lb, memory always ready
      opcode = 6'b100000;
      cyc("lb.f",  1'b1, 4'd0, W_FR,   1'b0);
      cyc("lb.d",  1'b1, 4'd1, W_DEC,  1'b0);
      cyc("lb.a",  1'b1, 4'd2, W_MADR, 1'b0);
      cyc("lb.r",  1'b1, 4'd3, W_MRD,  1'b0);
      cyc("lb.wb", 1'b1, 4'd4, W_MWB,  1'b0);

      // lb with one wait cycle in MEMRD
      cyc("lbs.f",  1'b1, 4'd0, W_FR,   1'b0);
      cyc("lbs.d",  1'b1, 4'd1, W_DEC,  1'b0);
      cyc("lbs.a",  1'b1, 4'd2, W_MADR, 1'b0);
      cyc("lbs.r0", 1'b0, 4'd3, W_MRD,  1'b0);
      cyc("lbs.r1", 1'b1, 4'd3, W_MRD,  1'b0);
      cyc("lbs.wb", 1'b1, 4'd4, W_MWB,  1'b0);

      // sb with two wait cycles in MEMWR
      opcode = 6'b101000;
      cyc("sb.f",  1'b1, 4'd0, W_FR,   1'b0);
      cyc("sb.d",  1'b1, 4'd1, W_DEC,  1'b0);
      cyc("sb.a",  1'b1, 4'd2, W_MADR, 1'b0);
      cyc("sb.w0", 1'b0, 4'd5, W_MWR,  1'b0);
      cyc("sb.w1", 1'b0, 4'd5, W_MWR,  1'b0);
      cyc("sb.w2", 1'b1, 4'd5, W_MWR,  1'b0);

      // R-type
      opcode = 6'b000000;
      cyc("rt.f",  1'b1, 4'd0, W_FR,  1'b0);
      cyc("rt.d",  1'b1, 4'd1, W_DEC, 1'b0);
      cyc("rt.ex", 1'b1, 4'd6, W_REX, 1'b0);
      cyc("rt.wb", 1'b1, 4'd7, W_RWB, 1'b0);

      // addi
      opcode = 6'b001000;
      cyc("ai.f",  1'b1, 4'd0,  W_FR,  1'b0);
      cyc("ai.d",  1'b1, 4'd1,  W_DEC, 1'b0);
      cyc("ai.ex", 1'b1, 4'd9,  W_AEX, 1'b0);
      cyc("ai.wb", 1'b1, 4'd10, W_AWB, 1'b0);

      // beq then j
      opcode = 6'b000100;
      cyc("bq.f",  1'b1, 4'd0, W_FR,  1'b0);
      cyc("bq.d",  1'b1, 4'd1, W_DEC, 1'b0);
      cyc("bq.ex", 1'b1, 4'd8, W_BEQ, 1'b0);
      opcode = 6'b000010;
      cyc("j.f",   1'b1, 4'd0,  W_FR,  1'b0);
      cyc("j.d",   1'b1, 4'd1,  W_DEC, 1'b0);
      cyc("j.ex",  1'b1, 4'd11, W_JEX, 1'b0);

      // mul: exactly four MULEX cycles, then R-type writeback
      opcode = 6'b011100;
      cyc("mu.f",  1'b1, 4'd0,  W_FR,  1'b0);
      cyc("mu.d",  1'b1, 4'd1,  W_DEC, 1'b0);
      cyc("mu.x0", 1'b1, 4'd12, W_MUL, 1'b0);
      cyc("mu.x1", 1'b1, 4'd12, W_MUL, 1'b0);
      cyc("mu.x2", 1'b1, 4'd12, W_MUL, 1'b0);
      cyc("mu.x3", 1'b1, 4'd12, W_MUL, 1'b0);
      cyc("mu.wb", 1'b1, 4'd7,  W_RWB, 1'b0);

      // illegal opcode: back to FETCH, single-cycle flag, no writes
      opcode = 6'b111111;
      cyc("il.f",  1'b1, 4'd0, W_FR,  1'b0);
      cyc("il.d",  1'b1, 4'd1, W_DEC, 1'b0);
      cyc("il.p",  1'b0, 4'd0, W_FN,  1'b1);
      cyc("il.q",  1'b0, 4'd0, W_FN,  1'b0);

      // reset in the middle of a multiply aborts it
      opcode = 6'b011100;
      cyc("ab.f",  1'b1, 4'd0,  W_FR,  1'b0);
      cyc("ab.d",  1'b1, 4'd1,  W_DEC, 1'b0);
      cyc("ab.x0", 1'b1, 4'd12, W_MUL, 1'b0);
      cyc("ab.x1", 1'b1, 4'd12, W_MUL, 1'b0);
      rst_n = 1'b0;
      #1;
      check("ab.rst.state", {28'd0, state}, 32'd0);
      check("ab.rst.ctl",   {17'd0, ow},    32'd0);
      @(posedge clk);
      #1;
      check("ab.hold.state", {28'd0, state}, 32'd0);
      check("ab.hold.ctl",   {17'd0, ow},    32'd0);
      rst_n = 1'b1;

      // full multiply again after the abort: counter starts fresh
      cyc("m2.f",  1'b1, 4'd0,  W_FR,  1'b0);
      cyc("m2.d",  1'b1, 4'd1,  W_DEC, 1'b0);
      cyc("m2.x0", 1'b1, 4'd12, W_MUL, 1'b0);
      cyc("m2.x1", 1'b1, 4'd12, W_MUL, 1'b0);
      cyc("m2.x2", 1'b1, 4'd12, W_MUL, 1'b0);
      cyc("m2.x3", 1'b1, 4'd12, W_MUL, 1'b0);
      cyc("m2.wb", 1'b1, 4'd7,  W_RWB, 1'b0);
      cyc("end.f", 1'b0, 4'd0,  W_FN,  1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
